// File: rtl/ps_packet_injector_if.sv
// Packet-source bus: host write port, PS-stage request/acknowledge channel and status.
// The injector drives through the master modport; host and stage use the slave view.
interface ps_packet_injector_if;
  logic        wr_en;
  logic [10:0] wr_cg;
  logic [6:0]  wr_dest;
  logic [33:0] wr_data;
  logic        full;
  logic [51:0] PACKET_OUT;
  logic        Send_out;
  logic        Ack_in;
  logic        busy;
  logic [15:0] sent_count;
  logic        ovf;
  logic        err;

  modport master (
    input  wr_en, wr_cg, wr_dest, wr_data, Ack_in,
    output full, PACKET_OUT, Send_out, busy, sent_count, ovf, err
  );

  modport slave (
    output wr_en, wr_cg, wr_dest, wr_data, Ack_in,
    input  full, PACKET_OUT, Send_out, busy, sent_count, ovf, err
  );
endinterface

// File: rtl/ps_packet_injector.sv
// Packet injector: a small FIFO of 52-bit packets feeding one four-phase
// return-to-zero handshake per packet toward the program-store stage.
// Ack_in is asynchronous and is only ever looked at after a 2-flop synchronizer.
module ps_packet_injector #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic                  CLK,
  input logic                  MR,
  ps_packet_injector_if.master bus
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_REQ   = 2'd2,
    S_REL   = 2'd3
  } state_t;

  logic [51:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  state_t            state_q;
  logic [51:0]       pkt_q;
  logic              send_q;
  logic [15:0]       sent_q;
  logic              ovf_q;
  logic              err_q;
  logic [WAIT_W-1:0] wait_q;
  logic              ack_meta_q, ack_s_q;

  logic full_d, empty_d, push_d, pop_d;

  // Push/pop decisions; a write while full is dropped even if a pop frees a slot this cycle.
  always_comb begin
    full_d  = (count_q == CNT_W'(DEPTH));
    empty_d = (count_q == '0);
    push_d  = bus.wr_en & ~full_d;
    pop_d   = (state_q == S_IDLE) & ~empty_d & ~ack_s_q;
  end

  // Two-flop synchronizer for the stage's acknowledge.
  always_ff @(posedge CLK) begin
    if (MR) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= bus.Ack_in;
      ack_s_q    <= ack_meta_q;
    end
  end

  // FIFO storage write port; contents need no reset since count gates every read.
  always_ff @(posedge CLK) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= {bus.wr_cg, bus.wr_dest, bus.wr_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge CLK) begin
    if (MR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag for writes attempted while full.
  always_ff @(posedge CLK) begin
    if (MR) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && full_d) begin
      ovf_q <= 1'b1;
    end
  end

  // Handshake FSM with registered packet/request outputs and the saturating wait timer.
  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      send_q  <= 1'b0;
      sent_q  <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_d) begin
            pkt_q   <= mem_q[rd_ptr_q];
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Packet has had a full cycle on the wires before the request rises.
          send_q  <= 1'b1;
          wait_q  <= '0;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (ack_s_q) begin
            send_q  <= 1'b0;
            wait_q  <= '0;
            state_q <= S_REL;
          end else if (wait_q != WAIT_W'(TIMEOUT)) begin
            wait_q <= wait_q + WAIT_W'(1);
            if (wait_q == WAIT_W'(TIMEOUT - 1)) err_q <= 1'b1;
          end
        end
        S_REL: begin
          if (!ack_s_q) begin
            sent_q  <= sent_q + 16'd1;
            state_q <= S_IDLE;
          end else if (wait_q != WAIT_W'(TIMEOUT)) begin
            wait_q <= wait_q + WAIT_W'(1);
            if (wait_q == WAIT_W'(TIMEOUT - 1)) err_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.full       = full_d;
  assign bus.PACKET_OUT = pkt_q;
  assign bus.Send_out   = send_q;
  assign bus.busy       = (state_q != S_IDLE) | ~empty_d;
  assign bus.sent_count = sent_q;
  assign bus.ovf        = ovf_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ps_packet_injector.sv
// Bench for ps_packet_injector: a behavioural model (packet queue plus handshake
// phases) is compared with the DUT every cycle, and a few literal values pin it.
module tb_ps_packet_injector;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic mr  = 1'b1;
  always #5 clk = ~clk;

  ps_packet_injector_if bus ();

  ps_packet_injector #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .CLK (clk),
    .MR  (mr),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // ---------------- behavioural model ----------------
  typedef enum int {PH_IDLE, PH_SETUP, PH_REQ, PH_REL} phase_t;
  logic [51:0] m_q[$];
  phase_t      m_phase = PH_IDLE;
  logic [51:0] m_pkt   = '0;
  logic        m_send  = 1'b0;
  logic [15:0] m_count = '0;
  logic        m_ovf   = 1'b0;
  logic        m_err   = 1'b0;
  int          m_wait  = 0;
  logic        m_a1 = 1'b0, m_a2 = 1'b0;
  logic        preload = 1'b0;

  always @(posedge clk) begin
    logic fnow, anow, dpush;
    if (mr) begin
      m_q.delete();
      m_phase = PH_IDLE; m_pkt = '0; m_send = 1'b0; m_count = '0;
      m_ovf = 1'b0; m_err = 1'b0; m_wait = 0; m_a1 = 1'b0; m_a2 = 1'b0;
    end else begin
      if (preload) m_count = 16'hFFFF;
      fnow  = (m_q.size() == DEPTH);
      anow  = m_a2;
      dpush = bus.wr_en && !fnow;
      if (bus.wr_en && fnow) m_ovf = 1'b1;
      case (m_phase)
        PH_IDLE:  if (m_q.size() > 0 && !anow) begin m_pkt = m_q.pop_front(); m_phase = PH_SETUP; end
        PH_SETUP: begin m_send = 1'b1; m_wait = 0; m_phase = PH_REQ; end
        PH_REQ: begin
          if (anow) begin m_send = 1'b0; m_wait = 0; m_phase = PH_REL; end
          else begin if (m_wait < TO) m_wait++; if (m_wait == TO) m_err = 1'b1; end
        end
        default: begin
          if (!anow) begin m_count = m_count + 16'd1; m_phase = PH_IDLE; end
          else begin if (m_wait < TO) m_wait++; if (m_wait == TO) m_err = 1'b1; end
        end
      endcase
      if (dpush) m_q.push_back({bus.wr_cg, bus.wr_dest, bus.wr_data});
      m_a2 = m_a1;
      m_a1 = bus.Ack_in;
    end
  end

  // ---------------- responder (PS stage side) ----------------
  int   resp_mode = 0;   // 0: manual level, 1: handshake, 2: silent
  logic force_ack = 1'b0;
  logic rand_dly  = 1'b0;
  int   rise_dly  = 2, fall_dly = 2;
  int   r_state = 0, r_cnt = 0;

  always @(negedge clk) begin
    if (mr) begin
      bus.Ack_in = 1'b0; r_state = 0;
    end else if (resp_mode == 0) begin
      bus.Ack_in = force_ack; r_state = 0;
    end else if (resp_mode == 1) begin
      case (r_state)
        0: if (bus.Send_out) begin
             r_cnt = rand_dly ? int'($urandom_range(0, 4)) : rise_dly; r_state = 1;
           end
        1: if (r_cnt == 0) begin bus.Ack_in = 1'b1; r_state = 2; end else r_cnt--;
        2: if (!bus.Send_out) begin
             r_cnt = rand_dly ? int'($urandom_range(0, 4)) : fall_dly; r_state = 3;
           end
        default: if (r_cnt == 0) begin bus.Ack_in = 1'b0; r_state = 0; end else r_cnt--;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  logic [6:0] dest_log[$];
  logic       prev_send = 1'b0;

  task automatic chk(input string name, input logic [51:0] act, input logic [51:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: land on the falling edge, compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("PACKET_OUT", bus.PACKET_OUT, m_pkt);
    chk("Send_out",   {51'd0, bus.Send_out}, {51'd0, m_send});
    chk("full",       {51'd0, bus.full}, {51'd0, (m_q.size() == DEPTH)});
    chk("busy",       {51'd0, bus.busy}, {51'd0, (m_phase != PH_IDLE) || (m_q.size() != 0)});
    chk("sent_count", {36'd0, bus.sent_count}, {36'd0, m_count});
    chk("ovf",        {51'd0, bus.ovf}, {51'd0, m_ovf});
    chk("err",        {51'd0, bus.err}, {51'd0, m_err});
    if (bus.Send_out && !prev_send) dest_log.push_back(bus.PACKET_OUT[40:34]);
    prev_send = bus.Send_out;
  endtask

  task automatic write_pkt(input logic [10:0] cg, input logic [6:0] dest, input logic [33:0] data);
    bus.wr_en = 1'b1; bus.wr_cg = cg; bus.wr_dest = dest; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_sent(input logic [15:0] target, input int budget, input string name);
    int n = 0;
    while (bus.sent_count != target && n < budget) begin tick(); n++; end
    chk(name, {36'd0, bus.sent_count}, {36'd0, target});
  endtask

  task automatic wait_send_high(input int budget, input string name);
    int n = 0;
    while (!bus.Send_out && n < budget) begin tick(); n++; end
    chk(name, {51'd0, bus.Send_out}, 52'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wr_en = 1'b0; bus.wr_cg = '0; bus.wr_dest = '0; bus.wr_data = '0;
    repeat (3) tick();
    mr = 1'b0;
    tick();
    chk("reset PACKET_OUT", bus.PACKET_OUT, 52'd0);
    chk("reset busy", {51'd0, bus.busy}, 52'd0);
    chk("reset full", {51'd0, bus.full}, 52'd0);

    // Single packet, responder 2 cycles each way.
    resp_mode = 1; rise_dly = 2; fall_dly = 2;
    write_pkt(11'h7FF, 7'd10, 34'h2_0000_0001);
    wait_sent(16'd1, 60, "single sent_count");
    chk("single PACKET_OUT", bus.PACKET_OUT, 52'hFFE2A00000001);

    // Back-to-back: hold Ack high so nothing pops while the FIFO fills.
    resp_mode = 0; force_ack = 1'b1;
    repeat (3) tick();
    dest_log.delete();
    for (int i = 0; i < 4; i++) write_pkt(11'(i + 1), 7'(i), 34'(i * 3));
    chk("b2b full", {51'd0, bus.full}, 52'd1);
    write_pkt(11'h123, 7'd9, 34'h1);
    chk("b2b ovf", {51'd0, bus.ovf}, 52'd1);
    force_ack = 1'b0;
    repeat (2) tick();
    resp_mode = 1; rise_dly = 1; fall_dly = 1;
    wait_sent(16'd5, 200, "b2b sent_count");
    chk("b2b count of packets", 52'(dest_log.size()), 52'd4);
    for (int i = 0; i < 4 && i < dest_log.size(); i++) chk("b2b order", 52'(dest_log[i]), 52'(i));

    // Four-phase: Ack held 20 cycles after Send_out falls.
    rise_dly = 0; fall_dly = 20;
    write_pkt(11'h001, 7'd33, 34'h3_FFFF_FFFF);
    write_pkt(11'h002, 7'd34, 34'h0_0000_0002);
    wait_sent(16'd6, 100, "hold first sent");
    chk("hold Send_out after first", {51'd0, bus.Send_out}, 52'd0);
    wait_sent(16'd7, 100, "hold second sent");
    chk("hold last PACKET_OUT dest", 52'(bus.PACKET_OUT[40:34]), 52'd34);

    // Timeout: silent stage, then a late acknowledge.
    resp_mode = 2; rise_dly = 1; fall_dly = 1;
    write_pkt(11'h055, 7'd77, 34'h0_ABCD_1234);
    wait_send_high(10, "timeout Send_out rise");
    repeat (20) tick();
    chk("timeout err", {51'd0, bus.err}, 52'd1);
    chk("timeout Send_out held", {51'd0, bus.Send_out}, 52'd1);
    resp_mode = 1;
    wait_sent(16'd8, 80, "timeout late completion");
    chk("timeout err sticky", {51'd0, bus.err}, 52'd1);

    // Randomized traffic with a mid-handshake reset.
    rand_dly = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c == 200) begin
        wait_send_high(100, "pre-reset Send_out");
        mr = 1'b1;
        tick();
        chk("reset Send_out drop", {51'd0, bus.Send_out}, 52'd0);
        tick();
        mr = 1'b0;
        chk("mid reset sent_count", {36'd0, bus.sent_count}, 52'd0);
        chk("mid reset err", {51'd0, bus.err}, 52'd0);
        chk("mid reset busy", {51'd0, bus.busy}, 52'd0);
      end
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_cg   = 11'($urandom);
      bus.wr_dest = 7'($urandom);
      bus.wr_data = {2'($urandom), 32'($urandom)};
      tick();
    end
    bus.wr_en = 1'b0;
    begin
      int n = 0;
      while ((bus.busy || bus.Ack_in) && n < 500) begin tick(); n++; end
      chk("drain busy", {51'd0, bus.busy}, 52'd0);
    end
    repeat (3) tick();

    // Counter wrap: preload 0xFFFF, one more handshake.
    rand_dly = 1'b0;
    force dut.sent_q = 16'hFFFF;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    release dut.sent_q;
    chk("preload sent_count", {36'd0, bus.sent_count}, 52'h0FFFF);
    write_pkt(11'h3AA, 7'd5, 34'h1_5555_5555);
    wait_sent(16'h0000, 60, "wrap sent_count");
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
